regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard for the pipelined RISC-V core. It provides NRD combinational read ports and NWR write-back ports. An optional same-cycle write-to-read bypass is included. Per-register pending-write tracking lets decode detect RAW/WAW hazards and stall without a separate hazard unit. It sits between decode (reads, issue) and write-back (writes, scoreboard clear).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/regfile_mp_sb.sv | 90 +++++++++
 tb/tb_regfile_mp_sb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and index helpers for the multi-port register file and its scoreboard.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Register address width; a two-entry file still needs one address bit.
    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    // Low bit of port 'idx' inside a flat bus of 'width'-bit fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on accepted issue,
// cleared on write-back or flush; answers issue acceptance and per-source busy lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic              iss_ready,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr_vec;

    // NOTE: every always_comb output is given a default before any conditional update,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) clr_vec[wr_addr[slice_lo(w, AW) +: AW]] = 1'b1;
        end
    end

    // A write-back landing this cycle frees the destination for a new producer.
    assign iss_ready = !flush && ((iss_rd == '0) || !busy_q[iss_rd] || clr_vec[iss_rd]);

    always_comb begin
        busy_d = flush ? '0 : (busy_q & ~clr_vec);
        // Applied after the clear so a new producer outranks the retiring one.
        if (iss_valid && iss_ready && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = busy_q[rd_addr[slice_lo(k, AW) +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy-bit scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write-back data and busy clears to the read ports.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NRD-1:0]  raw_busy;

    // NOTE: the array is reset explicitly because software expects every register to
    // read zero after reset; this keeps it in flops rather than a reset-less RAM macro.
    // Ascending port order means the highest-index port's assignment is the one that lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[slice_lo(w, AW) +: AW] != '0))
                    regs_q[wr_addr[slice_lo(w, AW) +: AW]] <= wr_data[slice_lo(w, XLEN) +: XLEN];
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rs_addr),
        .iss_ready (iss_ready),
        .rd_busy   (raw_busy)
    );

`ifdef RF_BYPASS_EN
    logic [NRD-1:0] byp_hit;

    always_comb begin
        rs_data = '0;
        byp_hit = '0;
        for (int k = 0; k < NRD; k++) begin
            rs_data[slice_lo(k, XLEN) +: XLEN] = regs_q[rs_addr[slice_lo(k, AW) +: AW]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (rs_addr[slice_lo(k, AW) +: AW] != '0) &&
                    (wr_addr[slice_lo(w, AW) +: AW] == rs_addr[slice_lo(k, AW) +: AW])) begin
                    rs_data[slice_lo(k, XLEN) +: XLEN] = wr_data[slice_lo(w, XLEN) +: XLEN];
                    byp_hit[k] = 1'b1;
                end
            end
        end
    end

    assign rs_busy = raw_busy & ~byp_hit;
`else
    always_comb begin
        rs_data = '0;
        for (int k = 0; k < NRD; k++) begin
            rs_data[slice_lo(k, XLEN) +: XLEN] = regs_q[rs_addr[slice_lo(k, AW) +: AW]];
        end
    end

    assign rs_busy = raw_busy;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus random traffic against a
// behavioural model; honours RF_BYPASS_EN the same way as the design.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;

    int n_checks = 0;
    int n_errors = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: what the outputs must be given current inputs and model state
    function automatic bit write_hits(input logic [AW-1:0] a);
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        return !flush && (iss_rd == 0 || !m_busy[iss_rd] || write_hits(iss_rd));
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int k);
        logic [AW-1:0]   a = rs_addr[k*AW +: AW];
        logic [XLEN-1:0] d = (a == 0) ? '0 : m_regs[a];
        if (BYP && a != 0)
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) d = wr_data[w*XLEN +: XLEN];
        return d;
    endfunction

    function automatic bit exp_busy(input int k);
        logic [AW-1:0] a = rs_addr[k*AW +: AW];
        return (a != 0) && m_busy[a] && !(BYP && write_hits(a));
    endfunction

    task automatic compare_outputs();
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rs_data[%0d]", k), 64'(rs_data[k*XLEN +: XLEN]), 64'(exp_data(k)));
            check($sformatf("rs_busy[%0d]", k), 64'(rs_busy[k]), 64'(exp_busy(k)));
        end
        check("iss_ready", 64'(iss_ready), 64'(exp_ready()));
    endtask

    task automatic update_model();
        bit rdy = exp_ready();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != 0) m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                if (wr_en[w]) m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
            if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; iss_valid = 0; iss_rd = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1; wr_addr[w*AW +: AW] = AW'(a); wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic read2(input int a0, input int a1);
        rs_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    initial begin
        idle();
        rs_addr = '0;
        for (int r = 0; r < NREGS; r++) begin m_regs[r] = 'x; m_busy[r] = 1'b0; end
        rst = 1;
        @(posedge clk); update_model(); #1;
        cycle();
        idle();

        // Reset state on every register and both ports.
        for (int r = 0; r < NREGS; r++) begin
            iss_rd = AW'(r);
            read2(r, NREGS - 1 - r);
            check("reset data0", 64'(rs_data[31:0]), 64'h0);
            check("reset data1", 64'(rs_data[63:32]), 64'h0);
            check("reset busy", 64'(rs_busy), 64'h0);
            check("reset ready", 64'(iss_ready), 64'h1);
        end
        cycle();

        // Same-address writes: higher port wins; r0 ignores writes.
        idle(); set_wr(0, 5, 32'h1234); set_wr(1, 5, 32'hBEEF); cycle();
        idle(); set_wr(0, 0, 32'hFF); read2(5, 0); cycle();
        idle(); read2(5, 0);
        check("r5 port1 wins", 64'(rs_data[31:0]), 64'hBEEF);
        check("r0 stays zero", 64'(rs_data[63:32]), 64'h0);
        cycle();

        // Issue r7, then RAW/WAW visibility, then write-back.
        idle(); iss_valid = 1; iss_rd = 7; #1;
        check("issue r7 ready", 64'(iss_ready), 64'h1);
        cycle();
        idle(); iss_valid = 1; iss_rd = 7; read2(7, 7);
        check("r7 busy", 64'(rs_busy), 64'h3);
        check("r7 WAW stall", 64'(iss_ready), 64'h0);
        cycle();
        idle(); set_wr(0, 7, 32'h55); read2(7, 3);
        check("r7 wb data", 64'(rs_data[31:0]), BYP ? 64'h55 : 64'h0);
        check("r7 wb busy", 64'(rs_busy[0]), BYP ? 64'h0 : 64'h1);
        cycle();
        idle(); read2(7, 7);
        check("r7 after wb", 64'(rs_data[31:0]), 64'h55);
        check("r7 free", 64'(rs_busy), 64'h0);
        cycle();

        // Issue and write the same register in one cycle: data lands, busy remains.
        idle(); iss_valid = 1; iss_rd = 9; set_wr(1, 9, 32'h10); read2(0, 0);
        check("r9 issue ready", 64'(iss_ready), 64'h1);
        cycle();
        idle(); read2(9, 9);
        check("r9 data", 64'(rs_data[63:32]), 64'h10);
        check("r9 busy", 64'(rs_busy), 64'h3);
        cycle();

        // Flush clears busy and refuses the issue that coincides with it.
        idle(); iss_valid = 1; iss_rd = 3; cycle();
        idle(); iss_valid = 1; iss_rd = 4; cycle();
        idle(); iss_valid = 1; iss_rd = 6; flush = 1; read2(3, 4);
        check("pre-flush busy", 64'(rs_busy), 64'h3);
        check("flush ready", 64'(iss_ready), 64'h0);
        cycle();
        idle(); iss_rd = 6; read2(3, 4);
        check("post-flush r3/r4", 64'(rs_busy), 64'h0);
        check("post-flush r6 ready", 64'(iss_ready), 64'h1);
        read2(6, 9);
        check("post-flush r6/r9", 64'(rs_busy), 64'h0);
        cycle();

        // Reset in the middle of traffic wins over the write.
        idle(); iss_valid = 1; iss_rd = 12; cycle();
        idle(); rst = 1; set_wr(0, 12, 32'h99); iss_valid = 1; iss_rd = 13; cycle();
        idle(); read2(12, 13);
        check("r12 after rst", 64'(rs_data[31:0]), 64'h0);
        check("busy after rst", 64'(rs_busy), 64'h0);
        cycle();

        // Random traffic; narrow address ranges keep collisions frequent.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 7));
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0)
                    set_wr(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7), $urandom);
            rs_addr = {AW'($urandom_range(0, 8)), AW'($urandom_range(0, 8))};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
